sparkle_locator: RTL and testbench

- Upstream stage of the sparkle animation ROM reader; drives its sparkle_here strobe and 12-bit sparkle_pixel address.
- Tracks one live sparkle sprite (20x20) on the 640x480 VGA scan.
- Compares the current scan coordinate against the sprite box and forms the ROM address: animation frame offset plus in-sprite pixel index.
- Owns spawn, frame-synchronous upward drift, animation-frame stepping and lifetime expiry.

---
 rtl/sparkle_locator.sv | 160 ++++++++++++++++
 tb/tb_sparkle_locator.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sparkle_locator.sv
// Tracks one live 20x20 sparkle sprite on the 640x480 scan and produces the
// registered ROM strobe/address for the pixel currently being scanned.
module sparkle_locator #(
  parameter int SPR_W           = 20,
  parameter int SPR_H           = 20,
  parameter int FRAME_PIX       = 400,
  parameter int NUM_FRAMES      = 4,
  parameter int FRAMES_PER_STEP = 15,
  parameter int LIFE_FRAMES     = 120,
  parameter int RISE            = 1,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic        frame_start,
  input  logic        spawn,
  input  logic [9:0]  spawn_x,
  input  logic [8:0]  spawn_y,
  output logic        sparkle_here,
  output logic [11:0] sparkle_pixel,
  output logic        active
);

  localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int STEP_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int LIFE_W  = (LIFE_FRAMES > 1) ? $clog2(LIFE_FRAMES) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [9:0]           pos_x_q, pos_x_d;
  logic [8:0]           pos_y_q, pos_y_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [11:0]          frame_base_q, frame_base_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [LIFE_W-1:0]    life_q, life_d;

  logic [10:0]          x_w, y_w, x_lo, x_hi, y_lo, y_hi;
  logic [11:0]          col_p0, row_p0;
  logic                 hit_p0;
  logic [11:0]          pixel_p0;
  logic                 here_p1;
  logic [11:0]          pixel_p1;

  function automatic logic [9:0] clamp_x(input logic [9:0] v);
    return (v > 10'(SCREEN_W - SPR_W)) ? 10'(SCREEN_W - SPR_W) : v;
  endfunction

  function automatic logic [8:0] clamp_y(input logic [8:0] v);
    return (v > 9'(SCREEN_H - SPR_H)) ? 9'(SCREEN_H - SPR_H) : v;
  endfunction

  // row*SPR_W as shift-add; the decomposition assumes SPR_W == 20
  function automatic logic [11:0] rom_addr(input logic [11:0] base,
                                           input logic [11:0] row,
                                           input logic [11:0] col);
    return base + (row << 4) + (row << 2) + col;
  endfunction

  always_comb begin
    state_d      = state_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    frame_d      = frame_q;
    frame_base_d = frame_base_q;
    step_d       = step_q;
    life_d       = life_q;
    if (spawn) begin
      state_d      = ACTIVE;
      pos_x_d      = clamp_x(spawn_x);
      pos_y_d      = clamp_y(spawn_y);
      frame_d      = '0;
      frame_base_d = '0;
      step_d       = '0;
      life_d       = '0;
    end else if (frame_start && (state_q == ACTIVE)) begin
      life_d = life_q + LIFE_W'(1);
      if (step_q == STEP_W'(FRAMES_PER_STEP - 1)) begin
        step_d = '0;
        // Frame base tracks frame*FRAME_PIX incrementally, avoiding a multiply
        if (frame_q == FRAME_W'(NUM_FRAMES - 1)) begin
          frame_d      = '0;
          frame_base_d = '0;
        end else begin
          frame_d      = frame_q + FRAME_W'(1);
          frame_base_d = frame_base_q + 12'(FRAME_PIX);
        end
      end else begin
        step_d = step_q + STEP_W'(1);
      end
      if (pos_y_q < 9'(RISE)) begin
        state_d = IDLE;
      end else begin
        pos_y_d = pos_y_q - 9'(RISE);
      end
      if (life_q == LIFE_W'(LIFE_FRAMES - 1)) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      frame_q      <= '0;
      frame_base_q <= '0;
      step_q       <= '0;
      life_q       <= '0;
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      frame_q      <= frame_d;
      frame_base_q <= frame_base_d;
      step_q       <= step_d;
      life_q       <= life_d;
    end
  end

  // Stage p0: hit test on the current scan coordinate (11-bit box bounds)
  assign x_w  = 11'(x);
  assign y_w  = 11'(y);
  assign x_lo = 11'(pos_x_q);
  assign x_hi = 11'(pos_x_q) + 11'(SPR_W);
  assign y_lo = 11'(pos_y_q);
  assign y_hi = 11'(pos_y_q) + 11'(SPR_H);

  assign hit_p0 = (state_q == ACTIVE) &&
                  (x_w < 11'(SCREEN_W)) && (y_w < 11'(SCREEN_H)) &&
                  (x_w >= x_lo) && (x_w < x_hi) &&
                  (y_w >= y_lo) && (y_w < y_hi);

  assign col_p0   = 12'(x) - 12'(pos_x_q);
  assign row_p0   = 12'(y) - 12'(pos_y_q);
  assign pixel_p0 = hit_p0 ? rom_addr(frame_base_q, row_p0, col_p0) : '0;

  // Stage p1: registered strobe and ROM address
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      here_p1  <= 1'b0;
      pixel_p1 <= '0;
    end else begin
      here_p1  <= hit_p0;
      pixel_p1 <= pixel_p0;
    end
  end

  assign sparkle_here  = here_p1;
  assign sparkle_pixel = pixel_p1;
  assign active        = (state_q == ACTIVE);

endmodule

// File: tb/tb_sparkle_locator.sv
// Directed bench for sparkle_locator: probes push expected ROM responses into
// a scoreboard that a separate monitor drains one cycle later.
module tb_sparkle_locator;

  logic        clk = 1'b0;
  logic        resetn;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        frame_start;
  logic        spawn;
  logic [9:0]  spawn_x;
  logic [8:0]  spawn_y;
  logic        sparkle_here;
  logic [11:0] sparkle_pixel;
  logic        active;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic        probe_req = 1'b0;
  logic        probe_d = 1'b0;
  logic [12:0] sb[$];

  sparkle_locator dut (
    .clk          (clk),
    .resetn       (resetn),
    .x            (x),
    .y            (y),
    .frame_start  (frame_start),
    .spawn        (spawn),
    .spawn_x      (spawn_x),
    .spawn_y      (spawn_y),
    .sparkle_here (sparkle_here),
    .sparkle_pixel(sparkle_pixel),
    .active       (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(posedge clk) probe_d <= probe_req;

  always @(negedge clk) begin
    if (probe_d) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL scoreboard_empty: got output with no expected entry");
      end else begin
        logic [12:0] e;
        e = sb.pop_front();
        check("sparkle_here", int'(sparkle_here), int'(e[12]));
        check("sparkle_pixel", int'(sparkle_pixel), int'(e[11:0]));
      end
    end
  end

  task automatic probe(input int px, input int py, input int eh, input int ep);
    x = 10'(px);
    y = 9'(py);
    probe_req = 1'b1;
    sb.push_back({1'(eh), 12'(ep)});
    @(negedge clk);
    probe_req = 1'b0;
    x = 10'd1000;
    y = 9'd500;
  endtask

  task automatic do_spawn(input int sx, input int sy, input logic with_fs);
    spawn = 1'b1;
    spawn_x = 10'(sx);
    spawn_y = 9'(sy);
    frame_start = with_fs;
    @(negedge clk);
    spawn = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    x = 10'd1000;
    y = 9'd500;
    frame_start = 1'b0;
    spawn = 1'b0;
    spawn_x = '0;
    spawn_y = '0;
    repeat (2) @(negedge clk);
    check("reset_here", int'(sparkle_here), 0);
    check("reset_pixel", int'(sparkle_pixel), 0);
    check("reset_active", int'(active), 0);
    resetn = 1'b1;
    @(negedge clk);

    probe(100, 200, 0, 0);

    // Basic hit map, frame 0
    do_spawn(100, 200, 1'b0);
    check("active_after_spawn", int'(active), 1);
    probe(100, 200, 1, 0);
    probe(119, 219, 1, 399);
    probe(120, 200, 0, 0);
    probe(99, 200, 0, 0);
    probe(100, 199, 0, 0);
    probe(110, 205, 1, 110);

    // Animation stepping with upward drift
    pulses(15);
    probe(100, 185, 1, 400);
    probe(119, 204, 1, 799);
    probe(100, 205, 0, 0);
    pulses(15);
    probe(105, 172, 1, 845);
    pulses(15);
    probe(100, 155, 1, 1200);
    probe(119, 174, 1, 1599);
    pulses(15);
    probe(100, 140, 1, 0);
    probe(101, 140, 1, 1);

    // Clamped spawn, restarting the live sparkle
    do_spawn(635, 475, 1'b0);
    probe(639, 479, 1, 399);
    probe(620, 460, 1, 0);
    probe(619, 460, 0, 0);

    // Drift to the top edge
    do_spawn(50, 3, 1'b0);
    pulses(2);
    probe(50, 1, 1, 0);
    probe(50, 0, 0, 0);
    pulses(1);
    probe(50, 0, 1, 0);
    check("active_at_top", int'(active), 1);
    pulses(1);
    check("active_after_top", int'(active), 0);
    probe(50, 0, 0, 0);

    // Lifetime expiry
    do_spawn(300, 450, 1'b0);
    pulses(119);
    check("active_life_119", int'(active), 1);
    probe(300, 331, 1, 1200);
    pulses(1);
    check("active_life_120", int'(active), 0);

    // Spawn coincident with frame_start
    do_spawn(200, 100, 1'b0);
    pulses(20);
    do_spawn(300, 250, 1'b1);
    probe(300, 250, 1, 0);
    probe(300, 249, 0, 0);
    pulses(119);
    check("active_coinc_119", int'(active), 1);
    probe(300, 131, 1, 1200);
    pulses(1);
    check("active_coinc_120", int'(active), 0);

    // Asynchronous reset while a hit is being presented
    do_spawn(10, 10, 1'b0);
    x = 10'd15;
    y = 9'd12;
    @(negedge clk);
    check("pre_reset_here", int'(sparkle_here), 1);
    check("pre_reset_pixel", int'(sparkle_pixel), 45);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_here", int'(sparkle_here), 0);
    check("async_reset_pixel", int'(sparkle_pixel), 0);
    check("async_reset_active", int'(active), 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_here", int'(sparkle_here), 0);
    check("post_reset_active", int'(active), 0);
    x = 10'd1000;
    y = 9'd500;

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
